psx_com_tx: RTL and testbench
=============================

Name: psx_com_tx

Overview:
- Transmitting end of the inter-board link: 6-bit data channel `com_channel`, strobe `com_clk`, frame qualifier `com_req`.
- Accepts a 32-bit word over a valid/ready handshake. Serialises it into six 6-bit beats, LSB chunk first, with a parity bit in the final beat.
- Sits on the controller/console-side FPGA and drives the GPIO link that the DE2-115 receiver samples.

Parameters:
- DIV, 25, system-clock cycles per `com_clk` half-period (≥1); 25 gives 1 MHz `com_clk` at 50 MHz.
- GAP, 4, idle cycles after `com_req` falls before the next word is accepted (≥0).

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  word available on in_data.
- in_data  in  32  word to send.
- in_ready  out  1  block can accept a word this cycle.
- com_channel  out  6  link data beat.
- com_clk  out  1  link strobe; receiver samples com_channel on its rising edge.
- com_req  out  1  high for the whole frame.
- busy  out  1  frame or gap in progress.
- frame_done  out  1  one-cycle pulse when com_req falls.

Behaviour:
- Reset (async, rst=1): all outputs 0.
  - in_ready goes to 1 on the first clk edge after rst deasserts (IDLE).
  - Reset mid-frame aborts immediately: com_req, com_clk and com_channel drop to 0, with no frame_done.
- Registered outputs only; no combinational path from in_* to com_*.
- Beat packing, word W:
  - beat k = W[6k+5:6k] for k=0..4.
  - beat 5 = {^W, 3'b000, W[31:30]}, i.e. even parity over all 32 bits in bit 5.
- States:
  - IDLE: in_ready=1, com_*=0, busy=0.
  - LOW: com_req=1, com_clk=0, com_channel=current beat.
  - HIGH: com_req=1, com_clk=1, com_channel held.
  - GAP: com_*=0, in_ready=0, busy=1.
- Transitions:
  - IDLE→LOW on in_valid&&in_ready at edge T.
    - W is latched into a 32-bit shift register; beat index = 0.
    - From T+1: com_req=1 and com_channel=beat0.
  - LOW→HIGH after exactly DIV cycles in LOW.
  - HIGH→LOW after DIV cycles if beat index < 5. Beat index increments; com_channel updates on the same edge com_clk falls.
  - HIGH→GAP after DIV cycles at beat 5.
    - com_req, com_clk and com_channel all go to 0 on the same edge.
    - frame_done=1 for that one cycle.
  - GAP→IDLE after GAP cycles (GAP=0: straight to IDLE on that edge).
- Frame timing:
  - com_req high for exactly 12·DIV cycles.
  - Word-to-word period is 12·DIV+GAP+1 cycles with in_valid held high.
- Data stability:
  - com_channel changes only while com_clk=0, at the falling edge, giving ≥DIV cycles of setup and DIV cycles of hold around each rising edge.
  - in_data changes after acceptance do not affect the frame.
  - in_valid while in_ready=0 is ignored; the upstream source must hold the word.
- Counters:
  - Half-period counter width $clog2(DIV+1); counts 0..DIV-1 and reloads on each state change.
  - 3-bit beat index counts 0..5 and never wraps past 5.
  - GAP counter width $clog2(GAP+1).

Decomposition:
- Package psx_com_pkg holds:
  - COM_W=6, BEATS=6, WORD_W=32;
  - enum com_tx_state_t {IDLE, LOW, HIGH, GAP};
  - function pack_beat(word, idx) implementing the packing rule (shared with the receiver's checker).
- No sub-module; a single FSM plus counters.

Test Plan:
- Word 0xDEADBEEF, DIV=2, GAP=2 → beats sampled at com_clk rises: 0x2F, 0x3B, 0x1B, 0x2B, 0x1E, 0x03. com_req high for 24 cycles; frame_done pulses once.
- Word 0x80000000 → beats 0x00 ×5, then 0x22 (parity 1, bits 31:30 = 2'b10).
- in_valid held high with two words, DIV=2, GAP=2 → second frame's com_req rises exactly 27 cycles after the first's. in_ready is 0 throughout the first frame and gap.
- in_data changed to 0x12345678 one cycle after 0xDEADBEEF is accepted → transmitted beats still match 0xDEADBEEF.
- rst asserted during HIGH of beat 3 → com_* go to 0 without waiting for a clock edge, and no frame_done. After release, a new word 0x00000001 sends beat0=0x01.
- DIV=1, GAP=0 with word 0xFFFFFFFF → com_clk toggles every cycle; beats are 0x3F ×5 then 0x03 (parity 0). in_ready returns 1 on the cycle after com_req falls.

Source files
------------

// File: rtl/psx_com_pkg.sv
// Shared definitions for the inter-board link: widths, transmitter states and the
// word-to-beat packing rule used by both ends of the link.
package psx_com_pkg;

   localparam int unsigned COM_W  = 6;
   localparam int unsigned BEATS  = 6;
   localparam int unsigned WORD_W = 32;

   typedef enum logic [1:0] {IDLE, LOW, HIGH, GAP} com_tx_state_t;

   // Beats 0..4 carry the word LSB chunk first; beat 5 carries the top two bits
   // plus even parity over the whole word in bit 5.
   function automatic logic [COM_W-1:0] pack_beat(input logic [WORD_W-1:0] word,
                                                  input logic [2:0]        idx);
      logic [COM_W-1:0] beat;
      case (idx)
         3'd0:    beat = word[5:0];
         3'd1:    beat = word[11:6];
         3'd2:    beat = word[17:12];
         3'd3:    beat = word[23:18];
         3'd4:    beat = word[29:24];
         default: beat = {^word, 3'b000, word[31:30]};
      endcase
      return beat;
   endfunction

endpackage

// File: rtl/psx_com_tx.sv
// Transmit side of the inter-board link: accepts a 32-bit word and serialises it as
// six 6-bit beats framed by com_req, strobed by com_clk.
module psx_com_tx
   import psx_com_pkg::*;
#(
   parameter int unsigned DIV = 25,
   parameter int unsigned GAP = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   input  logic [31:0] in_data,
   output logic        in_ready,
   output logic [5:0]  com_channel,
   output logic        com_clk,
   output logic        com_req,
   output logic        busy,
   output logic        frame_done
);

   localparam int unsigned CW = $clog2(DIV + 1);
   localparam int unsigned GW = (GAP > 0) ? $clog2(GAP + 1) : 1;

   localparam logic [CW-1:0] DIV_LAST  = CW'(DIV - 1);
   localparam logic [GW-1:0] GAP_LAST  = GW'(GAP - 1);
   localparam logic [2:0]    BEAT_LAST = 3'(BEATS - 1);

   com_tx_state_t      state_q;
   logic [WORD_W-1:0]  word_q;
   logic [CW-1:0]      div_cnt_q;
   logic [GW-1:0]      gap_cnt_q;
   logic [2:0]         beat_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         word_q      <= '0;
         div_cnt_q   <= '0;
         gap_cnt_q   <= '0;
         beat_q      <= '0;
         in_ready    <= 1'b0;
         com_channel <= '0;
         com_clk     <= 1'b0;
         com_req     <= 1'b0;
         busy        <= 1'b0;
         frame_done  <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         unique case (state_q)
            IDLE: begin
               in_ready <= 1'b1;
               if (in_valid && in_ready) begin
                  word_q      <= in_data;
                  beat_q      <= '0;
                  div_cnt_q   <= '0;
                  state_q     <= LOW;
                  in_ready    <= 1'b0;
                  busy        <= 1'b1;
                  com_req     <= 1'b1;
                  com_channel <= pack_beat(in_data, 3'd0);
               end
            end
            LOW: begin
               if (div_cnt_q == DIV_LAST) begin
                  div_cnt_q <= '0;
                  com_clk   <= 1'b1;
                  state_q   <= HIGH;
               end else begin
                  div_cnt_q <= div_cnt_q + 1'b1;
               end
            end
            HIGH: begin
               if (div_cnt_q == DIV_LAST) begin
                  div_cnt_q <= '0;
                  com_clk   <= 1'b0;
                  if (beat_q == BEAT_LAST) begin
                     com_req     <= 1'b0;
                     com_channel <= '0;
                     frame_done  <= 1'b1;
                     gap_cnt_q   <= '0;
                     if (GAP == 0) begin
                        state_q  <= IDLE;
                        busy     <= 1'b0;
                        in_ready <= 1'b1;
                     end else begin
                        state_q <= psx_com_pkg::GAP;
                     end
                  end else begin
                     // New beat launches on the same edge com_clk falls.
                     beat_q      <= beat_q + 3'd1;
                     com_channel <= pack_beat(word_q, beat_q + 3'd1);
                     state_q     <= LOW;
                  end
               end else begin
                  div_cnt_q <= div_cnt_q + 1'b1;
               end
            end
            psx_com_pkg::GAP: begin
               if (gap_cnt_q == GAP_LAST) begin
                  state_q  <= IDLE;
                  busy     <= 1'b0;
                  in_ready <= 1'b1;
               end else begin
                  gap_cnt_q <= gap_cnt_q + 1'b1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_psx_com_tx.sv
// Bench for psx_com_tx: two instances (DIV=2/GAP=2 and DIV=1/GAP=0) checked against a
// word-level model of the beat packing and frame timing.
module tb_psx_com_tx;

   localparam int LIMIT = 400;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_a, valid_a, ready_a, cclk_a, creq_a, busy_a, done_a;
   logic [31:0] data_a;
   logic [5:0]  chan_a;
   logic        rst_b, valid_b, ready_b, cclk_b, creq_b, busy_b, done_b;
   logic [31:0] data_b;
   logic [5:0]  chan_b;

   psx_com_tx #(.DIV(2), .GAP(2)) dut_a (
      .clk(clk), .rst(rst_a), .in_valid(valid_a), .in_data(data_a), .in_ready(ready_a),
      .com_channel(chan_a), .com_clk(cclk_a), .com_req(creq_a), .busy(busy_a),
      .frame_done(done_a)
   );

   psx_com_tx #(.DIV(1), .GAP(0)) dut_b (
      .clk(clk), .rst(rst_b), .in_valid(valid_b), .in_data(data_b), .in_ready(ready_b),
      .com_channel(chan_b), .com_clk(cclk_b), .com_req(creq_b), .busy(busy_b),
      .frame_done(done_b)
   );

   logic [5:0] m_chan [2];
   logic       m_clk [2], m_req [2], m_done [2], m_ready [2];
   assign m_chan[0] = chan_a;  assign m_chan[1] = chan_b;
   assign m_clk[0]  = cclk_a;  assign m_clk[1]  = cclk_b;
   assign m_req[0]  = creq_a;  assign m_req[1]  = creq_b;
   assign m_done[0] = done_a;  assign m_done[1] = done_b;
   assign m_ready[0] = ready_a; assign m_ready[1] = ready_b;

   // Link observer: records beats at com_clk rises and frame timing per instance.
   int         cyc;
   logic       p_clk [2], p_req [2];
   logic [5:0] p_chan [2];
   int         req_run [2], req_len [2], done_cnt [2], stab_err [2];
   int         rise_cyc [2], prev_rise_cyc [2];
   logic [5:0] beats0 [$];
   logic [5:0] beats1 [$];

   initial begin
      cyc = 0;
      for (int i = 0; i < 2; i++) begin
         p_clk[i] = 0; p_req[i] = 0; p_chan[i] = 0; req_run[i] = 0; req_len[i] = 0;
         done_cnt[i] = 0; stab_err[i] = 0; rise_cyc[i] = 0; prev_rise_cyc[i] = 0;
      end
   end

   always @(negedge clk) begin
      cyc <= cyc + 1;
      for (int i = 0; i < 2; i++) begin
         if (m_clk[i] && !p_clk[i]) begin
            if (i == 0) beats0.push_back(m_chan[i]);
            else        beats1.push_back(m_chan[i]);
         end
         if (m_req[i]) req_run[i] <= req_run[i] + 1;
         if (!m_req[i] && p_req[i]) begin
            req_len[i] <= req_run[i];
            req_run[i] <= 0;
         end
         if (m_req[i] && !p_req[i]) begin
            prev_rise_cyc[i] <= rise_cyc[i];
            rise_cyc[i]      <= cyc;
         end
         if (m_done[i]) done_cnt[i] <= done_cnt[i] + 1;
         if (m_chan[i] != p_chan[i] && m_clk[i]) stab_err[i] <= stab_err[i] + 1;
         p_clk[i]  <= m_clk[i];
         p_req[i]  <= m_req[i];
         p_chan[i] <= m_chan[i];
      end
   end

   int passed = 0;
   int total  = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // Reference packing straight from the word-level rule.
   function automatic logic [5:0] ref_beat(input logic [31:0] w, input int k);
      logic [31:0] v;
      if (k < 5) v = (w >> (6 * k)) & 32'h3F;
      else       v = (w >> 30) + (($countones(w) % 2) * 32);
      return v[5:0];
   endfunction

   task automatic drive(input int d, input logic v, input logic [31:0] w);
      if (d == 0) begin valid_a = v; data_a = w; end
      else        begin valid_b = v; data_b = w; end
   endtask

   // Offer w, wait for acceptance, then drop valid and put 'after' on the data bus.
   task automatic send(input int d, input logic [31:0] w, input logic [31:0] after);
      int n = 0;
      @(negedge clk);
      drive(d, 1'b1, w);
      while (!m_ready[d] && n < LIMIT) begin @(negedge clk); n++; end
      check("accept_timeout", 32'(n < LIMIT), 32'd1);
      @(negedge clk);
      drive(d, 1'b0, after);
   endtask

   task automatic wait_done(input int d);
      int n = 0;
      @(negedge clk);
      while (!m_done[d] && n < LIMIT) begin @(negedge clk); n++; end
      check("done_timeout", 32'(n < LIMIT), 32'd1);
   endtask

   task automatic check_frame(input int d, input logic [31:0] w);
      int sz;
      logic [5:0] b;
      sz = (d == 0) ? beats0.size() : beats1.size();
      check("beat_count", 32'(sz >= 6), 32'd1);
      for (int k = 0; k < 6; k++) begin
         if ((d == 0 && beats0.size() == 0) || (d == 1 && beats1.size() == 0)) break;
         b = (d == 0) ? beats0.pop_front() : beats1.pop_front();
         check($sformatf("beat%0d_of_%08h", k, w), 32'(b), 32'(ref_beat(w, k)));
      end
   endtask

   task automatic settle();
      repeat (3) @(negedge clk);
      #1;
   endtask

   initial begin
      logic [31:0] w1, w2;
      int zeros, d0, n;
      rst_a = 1'b1; rst_b = 1'b1;
      drive(0, 1'b0, 32'h0);
      drive(1, 1'b0, 32'h0);
      #2;
      check("rst_ready", 32'(ready_a), 32'd0);
      check("rst_req", 32'(creq_a), 32'd0);
      check("rst_clk", 32'(cclk_a), 32'd0);
      check("rst_chan", 32'(chan_a), 32'd0);
      check("rst_busy", 32'(busy_a), 32'd0);
      check("rst_done", 32'(done_a), 32'd0);
      repeat (2) @(negedge clk);
      rst_a = 1'b0; rst_b = 1'b0;
      #1 check("ready_before_edge", 32'(ready_a), 32'd0);
      @(negedge clk);
      check("ready_after_edge", 32'(ready_a), 32'd1);

      // DEADBEEF with the bus changed right after acceptance.
      d0 = done_cnt[0];
      send(0, 32'hDEADBEEF, 32'h12345678);
      check("busy_in_frame", 32'(busy_a), 32'd1);
      wait_done(0);
      settle();
      check_frame(0, 32'hDEADBEEF);
      check("req_len_div2", 32'(req_len[0]), 32'd24);
      check("done_once", 32'(done_cnt[0] - d0), 32'd1);

      send(0, 32'h80000000, 32'h0);
      wait_done(0);
      settle();
      check_frame(0, 32'h80000000);

      // Back-to-back words with valid held high.
      w1 = $urandom; w2 = $urandom;
      @(negedge clk);
      drive(0, 1'b1, w1);
      n = 0;
      while (!ready_a && n < LIMIT) begin @(negedge clk); n++; end
      @(negedge clk);
      drive(0, 1'b1, w2);
      zeros = 0;
      while (!ready_a && zeros < LIMIT) begin zeros++; @(negedge clk); end
      check("ready_low_span", 32'(zeros), 32'd26);
      @(negedge clk);
      drive(0, 1'b0, 32'h0);
      wait_done(0);
      settle();
      check("frame_period", 32'(rise_cyc[0] - prev_rise_cyc[0]), 32'd27);
      check_frame(0, w1);
      check_frame(0, w2);
      check("chan_stable_a", 32'(stab_err[0]), 32'd0);

      // Reset during the high phase of beat 3.
      d0 = done_cnt[0];
      send(0, $urandom, 32'h0);
      n = 0;
      while (beats0.size() < 4 && n < LIMIT) begin @(negedge clk); n++; end
      check("clk_high_before_rst", 32'(cclk_a), 32'd1);
      #1 rst_a = 1'b1;
      #1;
      check("abort_req", 32'(creq_a), 32'd0);
      check("abort_clk", 32'(cclk_a), 32'd0);
      check("abort_chan", 32'(chan_a), 32'd0);
      repeat (2) @(negedge clk);
      rst_a = 1'b0;
      settle();
      check("abort_no_done", 32'(done_cnt[0] - d0), 32'd0);
      beats0.delete();
      send(0, 32'h00000001, 32'h0);
      wait_done(0);
      settle();
      check_frame(0, 32'h00000001);

      // DIV=1, GAP=0 instance: fixed all-ones word then random words.
      for (int i = 0; i < 4; i++) begin
         w1 = (i == 0) ? 32'hFFFFFFFF : $urandom;
         send(1, w1, $urandom);
         wait_done(1);
         check("b_req_low_at_done", 32'(creq_b), 32'd0);
         check("b_ready_at_done", 32'(ready_b), 32'd1);
         settle();
         check("b_req_len", 32'(req_len[1]), 32'd12);
         check_frame(1, w1);
      end
      check("chan_stable_b", 32'(stab_err[1]), 32'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, %0d/%0d", passed, total);
      $fatal(1);
   end

endmodule
